l2_burst_responder: RTL and testbench

- Responder end of the L1-to-L2 burst read interface (l2_rreq / l2_addr / l2_burst_size / l2_rdata / l2_busy) used by the L1 instruction cache during line refill.
- Accepts one burst request, reads consecutive words from a synchronous backing SRAM port, and streams them back one word per cycle after a programmable access latency.
- Sits between the L1 caches and main memory, standing in for L2 in the uma memory subsystem.

---
 rtl/l2_burst_responder.sv | 149 ++++++++++++++
 tb/tb_l2_burst_responder.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_burst_responder.sv
// L2 stand-in: accepts one burst read, waits LATENCY cycles with l2_busy high,
// then streams consecutive backing-SRAM words one per cycle.
module l2_burst_responder #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned LATENCY = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              l2_rreq,
  input  logic [31:0]       l2_addr,
  input  logic [4:0]        l2_burst_size,
  output logic [31:0]       l2_rdata,
  output logic              l2_busy,
  output logic              l2_rvalid,
  output logic              err_drop,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned WCNT_W = 5;
  localparam logic [WCNT_W-1:0] MAX_BURST = WCNT_W'(16);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [WCNT_W-1:0]   icnt_q, icnt_d;
  logic [ADDR_W-1:0]   start_q, start_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [DATA_W-1:0]   rdata_d;
  logic                busy_d, rvalid_d, err_d, mem_re_d;

  logic [ADDR_W-1:0]   req_addr;
  logic [WCNT_W-1:0]   req_n_m1;
  logic                unused_addr_bits;

  assign req_addr = l2_addr[ADDR_W+1:2];
  // Word count minus one; 0 and anything above 16 mean a full 16-word burst.
  assign req_n_m1 = ((l2_burst_size == '0) || (l2_burst_size > MAX_BURST))
                    ? WCNT_W'(15) : WCNT_W'(l2_burst_size - WCNT_W'(1));
  assign unused_addr_bits = ^{32'(l2_addr >> (ADDR_W + 2)), l2_addr[1:0]};

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wcnt_q    <= '0;
      icnt_q    <= '0;
      start_q   <= '0;
      l2_busy   <= 1'b0;
      l2_rvalid <= 1'b0;
      l2_rdata  <= '0;
      err_drop  <= 1'b0;
      mem_re    <= 1'b0;
      mem_addr  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wcnt_q    <= wcnt_d;
      icnt_q    <= icnt_d;
      start_q   <= start_d;
      l2_busy   <= busy_d;
      l2_rvalid <= rvalid_d;
      l2_rdata  <= rdata_d;
      err_drop  <= err_d;
      mem_re    <= mem_re_d;
      mem_addr  <= mem_addr_d;
    end
  end

  // Next state, SRAM issue sequencing and output data.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wcnt_d     = wcnt_q;
    icnt_d     = icnt_q;
    start_d    = start_q;
    busy_d     = l2_busy;
    rvalid_d   = 1'b0;
    rdata_d    = l2_rdata;
    err_d      = err_drop;
    mem_re_d   = 1'b0;
    mem_addr_d = mem_addr;

    // Reads run back to back once started, independent of the delivery side.
    if (mem_re && (icnt_q != '0)) begin
      mem_re_d   = 1'b1;
      mem_addr_d = mem_addr + ADDR_W'(1);
      icnt_d     = icnt_q - WCNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (l2_rreq) begin
          state_d = WAIT;
          busy_d  = 1'b1;
          cnt_d   = CNT_W'(LATENCY - 1);
          wcnt_d  = req_n_m1;
          start_d = req_addr;
          // Shortest latency needs the first read issued straight from the request.
          if (LATENCY == 2) begin
            mem_re_d   = 1'b1;
            mem_addr_d = req_addr;
            icnt_d     = req_n_m1;
          end
        end
      end
      WAIT: begin
        if (l2_rreq) err_d = 1'b1;
        if (cnt_q == '0) begin
          state_d  = STREAM;
          busy_d   = 1'b0;
          rvalid_d = 1'b1;
          rdata_d  = mem_rdata;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
        if (cnt_q == CNT_W'(2)) begin
          mem_re_d   = 1'b1;
          mem_addr_d = start_q;
          icnt_d     = wcnt_q;
        end
      end
      STREAM: begin
        if (l2_rreq) err_d = 1'b1;
        if (wcnt_q == '0) begin
          state_d = IDLE;
        end else begin
          wcnt_d   = wcnt_q - WCNT_W'(1);
          rvalid_d = 1'b1;
          rdata_d  = mem_rdata;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_l2_burst_responder.sv
// Directed bench for l2_burst_responder: three instances cover LATENCY=4,
// LATENCY=2 and a 4-bit address space; SRAM word i holds 0xA0000000+i.
module tb_l2_burst_responder;

  logic        clk;
  logic        reset;
  logic        rreq   [3];
  logic [31:0] addr   [3];
  logic [4:0]  bsize  [3];
  logic [31:0] rdata  [3];
  logic        busy   [3];
  logic        rvalid [3];
  logic        err    [3];
  logic        mre    [3];
  logic [15:0] maddr  [3];
  logic [31:0] mrdata [3];
  logic [3:0]  maddr_s;

  int checks;
  int errors;

  logic        busy_tr [32];
  logic        rv_tr   [32];
  logic        re_tr   [32];
  logic        err_tr  [32];
  logic [31:0] rd_tr   [32];
  logic [15:0] ma_tr   [32];

  l2_burst_responder #(.ADDR_W(16), .LATENCY(4)) u_l4 (
    .clk(clk), .reset(reset), .l2_rreq(rreq[0]), .l2_addr(addr[0]),
    .l2_burst_size(bsize[0]), .l2_rdata(rdata[0]), .l2_busy(busy[0]),
    .l2_rvalid(rvalid[0]), .err_drop(err[0]), .mem_re(mre[0]),
    .mem_addr(maddr[0]), .mem_rdata(mrdata[0])
  );

  l2_burst_responder #(.ADDR_W(16), .LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset), .l2_rreq(rreq[1]), .l2_addr(addr[1]),
    .l2_burst_size(bsize[1]), .l2_rdata(rdata[1]), .l2_busy(busy[1]),
    .l2_rvalid(rvalid[1]), .err_drop(err[1]), .mem_re(mre[1]),
    .mem_addr(maddr[1]), .mem_rdata(mrdata[1])
  );

  l2_burst_responder #(.ADDR_W(4), .LATENCY(4)) u_wrap (
    .clk(clk), .reset(reset), .l2_rreq(rreq[2]), .l2_addr(addr[2]),
    .l2_burst_size(bsize[2]), .l2_rdata(rdata[2]), .l2_busy(busy[2]),
    .l2_rvalid(rvalid[2]), .err_drop(err[2]), .mem_re(mre[2]),
    .mem_addr(maddr_s), .mem_rdata(mrdata[2])
  );

  assign maddr[2] = {12'd0, maddr_s};

  always #5 clk = ~clk;

  // Synchronous SRAM models.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++)
      if (mre[i]) mrdata[i] <= 32'hA000_0000 + 32'(maddr[i]);
  end

  // Request in the current cycle (cycle 0), then record cycles 1..ncyc.
  task automatic run_burst(input int sel, input logic [31:0] a, input logic [4:0] s,
                           input int ncyc, input int pa, input int pb, input int rst_at);
    rreq[sel]  = 1'b1;
    addr[sel]  = a;
    bsize[sel] = s;
    @(negedge clk);
    for (int t = 1; t <= ncyc; t++) begin
      rreq[sel]  = (t == pa) || (t == pb);
      reset      = (t == rst_at);
      addr[sel]  = $urandom;
      bsize[sel] = 5'($urandom);
      busy_tr[t] = busy[sel];
      rv_tr[t]   = rvalid[sel];
      re_tr[t]   = mre[sel];
      err_tr[t]  = err[sel];
      rd_tr[t]   = rdata[sel];
      ma_tr[t]   = maddr[sel];
      @(negedge clk);
    end
    rreq[sel] = 1'b0;
    reset     = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (busy[i] !== 1'b0 || rvalid[i] !== 1'b0 || mre[i] !== 1'b0 || err[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset flags dut%0d got busy=%b rv=%b re=%b err=%b exp 0", i,
                 busy[i], rvalid[i], mre[i], err[i]);
      end
      checks++;
      if (rdata[i] !== 32'h0 || maddr[i] !== 16'h0) begin
        errors++;
        $display("FAIL reset data dut%0d got rdata=%h maddr=%h exp 0", i, rdata[i], maddr[i]);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int nre;
    logic eb, ev, er;
    nre = 0;
    run_burst(0, 32'h0000_0100, 5'd8, 14, 0, 0, 0);
    for (int t = 1; t <= 14; t++) begin
      eb = (t <= 4);
      ev = (t >= 5 && t <= 12);
      er = (t >= 3 && t <= 10);
      checks++;
      if (busy_tr[t] !== eb || rv_tr[t] !== ev || re_tr[t] !== er) begin
        errors++;
        $display("FAIL basic strobes t=%0d got busy=%b rv=%b re=%b exp %b %b %b", t,
                 busy_tr[t], rv_tr[t], re_tr[t], eb, ev, er);
      end
      if (ev) begin
        checks++;
        if (rd_tr[t] !== 32'hA000_0040 + 32'(t - 5)) begin
          errors++;
          $display("FAIL basic rdata t=%0d got %h exp %h", t, rd_tr[t], 32'hA000_0040 + 32'(t - 5));
        end
      end
      if (er) begin
        checks++;
        if (ma_tr[t] !== 16'h40 + 16'(t - 3)) begin
          errors++;
          $display("FAIL basic mem_addr t=%0d got %h exp %h", t, ma_tr[t], 16'h40 + 16'(t - 3));
        end
      end
      if (re_tr[t] === 1'b1) nre++;
    end
    checks++;
    if (rd_tr[14] !== 32'hA000_0047) begin
      errors++;
      $display("FAIL basic hold got %h exp a0000047", rd_tr[14]);
    end
    checks++;
    if (nre !== 8) begin
      errors++;
      $display("FAIL basic mem_re count got %0d exp 8", nre);
    end
  endtask

  task automatic test_back_to_back();
    run_burst(1, 32'h0000_0020, 5'd1, 3, 0, 0, 0);
    checks++;
    if (busy_tr[1] !== 1'b1 || busy_tr[2] !== 1'b1 || busy_tr[3] !== 1'b0) begin
      errors++;
      $display("FAIL single busy got %b%b%b exp 110", busy_tr[1], busy_tr[2], busy_tr[3]);
    end
    checks++;
    if (re_tr[1] !== 1'b1 || re_tr[2] !== 1'b0 || ma_tr[1] !== 16'h8) begin
      errors++;
      $display("FAIL single mem_re got re=%b%b addr=%h exp 10 0008", re_tr[1], re_tr[2], ma_tr[1]);
    end
    checks++;
    if (rv_tr[3] !== 1'b1 || rv_tr[2] !== 1'b0 || rd_tr[3] !== 32'hA000_0008) begin
      errors++;
      $display("FAIL single word got rv=%b rdata=%h exp 1 a0000008", rv_tr[3], rd_tr[3]);
    end
    // Request issued in cycle 4 of the previous burst.
    run_burst(1, 32'h0000_0040, 5'd2, 5, 0, 0, 0);
    checks++;
    if (rv_tr[3] !== 1'b1 || rd_tr[3] !== 32'hA000_0010 || rv_tr[4] !== 1'b1 ||
        rd_tr[4] !== 32'hA000_0011 || rv_tr[5] !== 1'b0) begin
      errors++;
      $display("FAIL b2b words got %b:%h %b:%h %b exp 1:a0000010 1:a0000011 0",
               rv_tr[3], rd_tr[3], rv_tr[4], rd_tr[4], rv_tr[5]);
    end
    checks++;
    if (err[1] !== 1'b0) begin
      errors++;
      $display("FAIL b2b err_drop got %b exp 0", err[1]);
    end
  endtask

  task automatic test_clamp();
    logic [4:0]  sz  [2];
    logic [31:0] ba  [2];
    int nre, nrv;
    sz[0] = 5'd0;  ba[0] = 32'h0000_0200;
    sz[1] = 5'd20; ba[1] = 32'h0000_0400;
    for (int r = 0; r < 2; r++) begin
      nre = 0;
      nrv = 0;
      run_burst(0, ba[r], sz[r], 22, 0, 0, 0);
      for (int t = 1; t <= 22; t++) begin
        if (re_tr[t] === 1'b1) nre++;
        if (rv_tr[t] === 1'b1) begin
          nrv++;
          checks++;
          if (rd_tr[t] !== 32'hA000_0000 + (ba[r] >> 2) + 32'(t - 5)) begin
            errors++;
            $display("FAIL clamp%0d rdata t=%0d got %h exp %h", r, t, rd_tr[t],
                     32'hA000_0000 + (ba[r] >> 2) + 32'(t - 5));
          end
        end
      end
      checks++;
      if (nre !== 16 || nrv !== 16 || rv_tr[20] !== 1'b1 || rv_tr[21] !== 1'b0) begin
        errors++;
        $display("FAIL clamp%0d counts got re=%0d rv=%0d last=%b%b exp 16 16 10", r, nre, nrv,
                 rv_tr[20], rv_tr[21]);
      end
    end
  endtask

  task automatic test_drop();
    int nre;
    nre = 0;
    run_burst(0, 32'h0000_0300, 5'd4, 11, 2, 8, 0);
    for (int t = 1; t <= 11; t++) begin
      if (re_tr[t] === 1'b1) nre++;
      checks++;
      if (rv_tr[t] !== (t >= 5 && t <= 8)) begin
        errors++;
        $display("FAIL drop rvalid t=%0d got %b exp %b", t, rv_tr[t], (t >= 5 && t <= 8));
      end
      if (t >= 5 && t <= 8) begin
        checks++;
        if (rd_tr[t] !== 32'hA000_00C0 + 32'(t - 5)) begin
          errors++;
          $display("FAIL drop rdata t=%0d got %h exp %h", t, rd_tr[t], 32'hA000_00C0 + 32'(t - 5));
        end
      end
    end
    checks++;
    if (nre !== 4 || re_tr[7] !== 1'b0) begin
      errors++;
      $display("FAIL drop mem_re count got %0d exp 4", nre);
    end
    checks++;
    if (err_tr[2] !== 1'b0 || err_tr[3] !== 1'b1 || err_tr[11] !== 1'b1) begin
      errors++;
      $display("FAIL drop err_drop got %b%b%b exp 011", err_tr[2], err_tr[3], err_tr[11]);
    end
  endtask

  task automatic test_reset_mid();
    int nre;
    run_burst(0, 32'h0000_0500, 5'd8, 12, 0, 0, 7);
    checks++;
    if (rv_tr[7] !== 1'b1 || rd_tr[7] !== 32'hA000_0142) begin
      errors++;
      $display("FAIL rstmid pre got %b:%h exp 1:a0000142", rv_tr[7], rd_tr[7]);
    end
    for (int t = 8; t <= 12; t++) begin
      checks++;
      if (busy_tr[t] !== 1'b0 || rv_tr[t] !== 1'b0 || re_tr[t] !== 1'b0 || rd_tr[t] !== 32'h0 ||
          ma_tr[t] !== 16'h0 || err_tr[t] !== 1'b0) begin
        errors++;
        $display("FAIL rstmid t=%0d got busy=%b rv=%b re=%b rd=%h ma=%h err=%b exp all 0", t,
                 busy_tr[t], rv_tr[t], re_tr[t], rd_tr[t], ma_tr[t], err_tr[t]);
      end
    end
    nre = 0;
    run_burst(0, 32'h0000_0104, 5'd3, 9, 0, 0, 0);
    for (int t = 1; t <= 9; t++) if (re_tr[t] === 1'b1) nre++;
    checks++;
    if (nre !== 3 || rd_tr[5] !== 32'hA000_0041 || rd_tr[6] !== 32'hA000_0042 ||
        rd_tr[7] !== 32'hA000_0043 || rv_tr[7] !== 1'b1 || rv_tr[8] !== 1'b0) begin
      errors++;
      $display("FAIL rstmid fresh got re=%0d %h %h %h rv=%b%b exp 3 a0000041 a0000042 a0000043 10",
               nre, rd_tr[5], rd_tr[6], rd_tr[7], rv_tr[7], rv_tr[8]);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] ea;
    int nre;
    nre = 0;
    run_burst(2, 32'h0000_0038, 5'd4, 10, 0, 0, 0);
    for (int t = 1; t <= 10; t++) begin
      if (re_tr[t] === 1'b1) nre++;
      if (t >= 3 && t <= 6) begin
        ea = 16'((14 + t - 3) % 16);
        checks++;
        if (re_tr[t] !== 1'b1 || ma_tr[t] !== ea) begin
          errors++;
          $display("FAIL wrap mem_addr t=%0d got re=%b %h exp 1 %h", t, re_tr[t], ma_tr[t], ea);
        end
      end
      if (t >= 5 && t <= 8) begin
        ea = 16'((14 + t - 5) % 16);
        checks++;
        if (rv_tr[t] !== 1'b1 || rd_tr[t] !== 32'hA000_0000 + 32'(ea)) begin
          errors++;
          $display("FAIL wrap rdata t=%0d got %b:%h exp 1:%h", t, rv_tr[t], rd_tr[t],
                   32'hA000_0000 + 32'(ea));
        end
      end
    end
    checks++;
    if (nre !== 4) begin
      errors++;
      $display("FAIL wrap mem_re count got %0d exp 4", nre);
    end
  endtask

  initial begin
    clk    = 1'b0;
    reset  = 1'b1;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 3; i++) begin
      rreq[i]  = 1'b0;
      addr[i]  = '0;
      bsize[i] = '0;
    end
    test_reset();
    test_basic();
    test_back_to_back();
    test_clamp();
    test_drop();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
